// File: rtl/alu_input_sequencer.sv
// Button/switch front end for the ALU: synchronizes and debounces the load and
// clear buttons, then issues one-cycle load strobes in the order A -> B -> OP.

module alu_input_sequencer_debounce #(
  parameter int DEBOUNCE_MAX = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MAX - 1);

  logic [1:0]    sync_pipe;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The flip happens on the DEBOUNCE_MAX-th consecutive mismatching cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      level     <= 1'b0;
      level_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn};
      level_q   <= level;
      if (sync_pipe[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_q;
endmodule

module alu_input_sequencer #(
  parameter int NB_DATA      = 8,
  parameter int NB_OP        = 6,
  parameter int DEBOUNCE_MAX = 1_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_btn_load,
  input  logic               i_btn_clear,
  input  logic [NB_DATA-1:0] i_sw,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_en_A,
  output logic               o_en_B,
  output logic               o_en_OP,
  output logic [1:0]         o_state,
  output logic               o_ready
);
  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, SHOW = 2'd3} state_t;

  if (NB_OP > NB_DATA) begin : g_bad_op
    $error("NB_OP must not exceed NB_DATA");
  end
  if (DEBOUNCE_MAX < 1) begin : g_bad_db
    $error("DEBOUNCE_MAX must be at least 1");
  end

  logic [1:0] btn;
  logic [1:0] press;
  assign btn = {i_btn_clear, i_btn_load};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    alu_input_sequencer_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_db (
      .clk   (i_clk),
      .rst_n (i_rst),
      .btn   (btn[g]),
      .press (press[g])
    );
  end

  state_t             state;
  state_t             state_nxt;
  logic [NB_DATA-1:0] sw_s1;
  logic [NB_DATA-1:0] sw_s2;
  logic [NB_DATA-1:0] data_nxt;
  logic [2:0]         en;
  logic [2:0]         en_nxt;

  // Clear outranks load; SHOW accepts a load as a fresh A to chain calculations.
  always_comb begin
    state_nxt = state;
    data_nxt  = o_data;
    en_nxt    = '0;
    if (press[1]) begin
      state_nxt = LOAD_A;
    end else if (press[0]) begin
      data_nxt = sw_s2;
      case (state)
        LOAD_A, SHOW: begin en_nxt = 3'b001; state_nxt = LOAD_B;  end
        LOAD_B:       begin en_nxt = 3'b010; state_nxt = LOAD_OP; end
        LOAD_OP:      begin en_nxt = 3'b100; state_nxt = SHOW;    end
        default:      begin en_nxt = 3'b000; state_nxt = LOAD_A;  end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state  <= LOAD_A;
      o_data <= '0;
      en     <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      state  <= state_nxt;
      o_data <= data_nxt;
      en     <= en_nxt;
      sw_s1  <= i_sw;
      sw_s2  <= sw_s1;
    end
  end

  assign o_en_A  = en[0];
  assign o_en_B  = en[1];
  assign o_en_OP = en[2];
  assign o_state = state;
  assign o_ready = (state == SHOW);
endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: directed press table, bounce/reset corner
// sequences, and a random run against a sliding-window reference model.
module tb_alu_input_sequencer;
  localparam int NB_DATA = 8;
  localparam int DM      = 4;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               i_btn_load = 1'b0;
  logic               i_btn_clear = 1'b0;
  logic [NB_DATA-1:0] i_sw = '0;
  logic [NB_DATA-1:0] o_data;
  logic               o_en_A, o_en_B, o_en_OP;
  logic [1:0]         o_state;
  logic               o_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  alu_input_sequencer #(.NB_DATA(NB_DATA), .NB_OP(6), .DEBOUNCE_MAX(DM)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_btn_load  (i_btn_load),
    .i_btn_clear (i_btn_clear),
    .i_sw        (i_sw),
    .o_data      (o_data),
    .o_en_A      (o_en_A),
    .o_en_B      (o_en_B),
    .o_en_OP     (o_en_OP),
    .o_state     (o_state),
    .o_ready     (o_ready)
  );

  // Reference model: a level flips once the last DM synchronized samples all disagree with it.
  bit [1:0] m_s1, m_s2, m_lvl, m_prev;
  bit [1:0] win[$];
  bit [7:0] m_sw1, m_sw2, m_data;
  bit [2:0] m_en;
  int       m_step;

  task automatic model_step(input bit rst, input bit bl, input bit bc, input logic [7:0] sw);
    bit [1:0] ev;
    bit       flip;
    int       idx;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0;
      m_sw1 = 0; m_sw2 = 0; m_data = 0; m_en = 0; m_step = 0;
      win.delete();
      for (int i = 0; i < DM; i++) win.push_back(2'b00);
      return;
    end
    ev   = m_lvl & ~m_prev;
    m_en = 0;
    if (ev[1]) m_step = 0;
    else if (ev[0]) begin
      idx    = m_step % 3;
      m_en   = 3'(1 << idx);
      m_data = m_sw2;
      m_step = idx + 1;
    end
    m_prev = m_lvl;
    win.push_back(m_s2);
    void'(win.pop_front());
    for (int b = 0; b < 2; b++) begin
      flip = 1;
      foreach (win[i]) if (win[i][b] == m_lvl[b]) flip = 0;
      if (flip) m_lvl[b] = ~m_lvl[b];
    end
    m_s2 = m_s1;  m_s1 = {bc, bl};
    m_sw2 = m_sw1; m_sw1 = sw;
  endtask

  function automatic logic [13:0] outs();
    return {o_en_OP, o_en_B, o_en_A, o_data, o_state, o_ready};
  endfunction

  function automatic logic [13:0] model_outs();
    return {m_en, m_data, 2'(m_step), m_step == 3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: inputs held over the rising edge, outputs sampled at the falling edge.
  task automatic cyc(input bit rst, input bit bl, input bit bc, input logic [7:0] sw);
    i_rst = rst; i_btn_load = bl; i_btn_clear = bc; i_sw = sw;
    @(posedge i_clk);
    model_step(rst, bl, bc, sw);
    @(negedge i_clk);
  endtask

  // Clean press: 8 high, 8 low; the strobe belongs in cycle 7 of the press.
  task automatic press(input string name, input bit ld, input bit cl, input logic [7:0] sw,
                       input logic [2:0] en, input logic [7:0] data, input logic [1:0] st,
                       input bit rdy);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, ld && k < 8, cl && k < 8, sw);
      if (k == 6) chk({name, " strobe"}, outs(), {en, data, st, rdy});
      else if (k == 15) chk({name, " after"}, outs(), {3'b000, data, st, rdy});
      else chk({name, " idle"}, {o_en_OP, o_en_B, o_en_A}, 3'b000);
    end
  endtask

  typedef struct {
    bit         ld;
    bit         cl;
    logic [7:0] sw;
    logic [2:0] en;
    logic [7:0] data;
    logic [1:0] st;
    bit         rdy;
  } vec_t;

  initial begin
    vec_t tbl[8];
    bit   b;
    int   t, len;
    int   rl, rc;
    bit   bl, bc, rst;
    logic [7:0] sw;

    tbl[0] = '{1, 0, 8'h05, 3'b001, 8'h05, 2'd1, 0};
    tbl[1] = '{1, 0, 8'h03, 3'b010, 8'h03, 2'd2, 0};
    tbl[2] = '{1, 0, 8'h20, 3'b100, 8'h20, 2'd3, 1};
    tbl[3] = '{1, 0, 8'h7F, 3'b001, 8'h7F, 2'd1, 0};
    tbl[4] = '{1, 0, 8'h11, 3'b010, 8'h11, 2'd2, 0};
    tbl[5] = '{1, 1, 8'h22, 3'b000, 8'h11, 2'd0, 0};
    tbl[6] = '{0, 1, 8'h33, 3'b000, 8'h11, 2'd0, 0};
    tbl[7] = '{1, 0, 8'h44, 3'b001, 8'h44, 2'd1, 0};

    // Reset with buttons toggling, then one released cycle
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, k[0], ~k[0], 8'($urandom));
      chk($sformatf("reset%0d", k), outs(), 14'h0);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset release", outs(), 14'h0);

    foreach (tbl[i])
      press($sformatf("vec%0d", i), tbl[i].ld, tbl[i].cl, tbl[i].sw,
            tbl[i].en, tbl[i].data, tbl[i].st, tbl[i].rdy);

    // Reset lands in the cycle the load event fires (state is LOAD_B here)
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h66);
      chk("rstmid pre", {o_en_OP, o_en_B, o_en_A}, 3'b000);
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h66);
    chk("rstmid kill", outs(), 14'h0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h66);
      chk("rstmid quiet", outs(), 14'h0);
    end
    press("rstmid press", 1, 0, 8'h77, 3'b001, 8'h77, 2'd1, 0);
    press("clear", 0, 1, 8'h00, 3'b000, 8'h77, 2'd0, 0);

    // Bounce: runs of 1-3 cycles for at least 40 cycles, ending low, then hold
    b = 1; t = 0;
    while (t < 40 || b == 0) begin
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) begin
        cyc(1'b1, b, 1'b0, 8'h5A);
        chk("bounce quiet", {o_en_OP, o_en_B, o_en_A}, 3'b000);
        t++;
      end
      b = ~b;
    end
    for (int k = 0; k < 24; k++) begin
      cyc(1'b1, k < 12, 1'b0, 8'h5A);
      if (k == 6) chk("bounce strobe", outs(), {3'b001, 8'h5A, 2'd1, 1'b0});
      else chk("bounce single", {o_en_OP, o_en_B, o_en_A}, 3'b000);
    end

    // Random buttons, switches and occasional reset against the model
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    rl = 0; rc = 0; bl = 0; bc = 0; sw = 0;
    for (int n = 0; n < 2500; n++) begin
      if (rl == 0) begin bl = ~bl; rl = $urandom_range(1, 10); end
      if (rc == 0) begin bc = ~bc; rc = bc ? $urandom_range(1, 6) : $urandom_range(5, 40); end
      rl--; rc--;
      if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
      rst = ($urandom_range(0, 299) != 0);
      cyc(rst, bl, bc, sw);
      chk($sformatf("rand%0d", n), outs(), model_outs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Front-end controller that turns a raw push-button and the data switches into the load strobes consumed by the ALU operand/opcode registers. It sits between the board I/O and the `i_data` / `i_en_A` / `i_en_B` / `i_en_OP` inputs of the ALU top level, and drives them in the fixed order A → B → OP. It synchronizes and debounces both buttons, then steps a load state machine on each debounced press. It exposes the current step so LEDs can show which operand is expected next.

## Interface
- `NB_DATA`, 8: width of the switch bus and `o_data`.
- `NB_OP`, 6: opcode width. Informational only; the OP load presents the full `NB_DATA` word, and the downstream register keeps the LSBs.
- `DEBOUNCE_MAX`, 1_000_000: number of consecutive stable cycles needed to accept a button level change. Must be ≥ 1. Counter width is `$clog2(DEBOUNCE_MAX+1)`.

Ports:
- `i_clk`  in  1  system clock; the block's only clock.
- `i_rst`  in  1  reset, synchronous, active-low.
- `i_btn_load`  in  1  raw, asynchronous, bouncing load button, active-high.
- `i_btn_clear`  in  1  raw, asynchronous, bouncing clear button, active-high.
- `i_sw`  in  NB_DATA  raw slide switches, quasi-static.
- `o_data`  out  NB_DATA  registered switch snapshot, to ALU `i_data`.
- `o_en_A`  out  1  one-cycle load strobe for operand A.
- `o_en_B`  out  1  one-cycle load strobe for operand B.
- `o_en_OP`  out  1  one-cycle load strobe for the opcode.
- `o_state`  out  2  current step: 0 = LOAD_A, 1 = LOAD_B, 2 = LOAD_OP, 3 = SHOW.
- `o_ready`  out  1  high while in SHOW, meaning A, B and OP are all loaded.

## Operation
- **Synchronizers.** `i_btn_load`, `i_btn_clear` and every bit of `i_sw` pass through a 2-FF synchronizer.
- **Debouncer (one per button).**
  - Holds a debounced level and a counter.
  - Each cycle the synchronized input differs from the debounced level, the counter increments. When the counter reaches `DEBOUNCE_MAX`, the debounced level flips and the counter clears.
  - Any cycle where the synchronized input equals the debounced level clears the counter.
- **Edge detect.** An event fires when the debounced level is 1 and its previous-cycle copy is 0. Only presses generate events; releases do not.
- **FSM.** Reset state is LOAD_A.
  - Load event in LOAD_A: capture synchronized `i_sw` into `o_data`, pulse `o_en_A`, go to LOAD_B.
  - Load event in LOAD_B: capture, pulse `o_en_B`, go to LOAD_OP.
  - Load event in LOAD_OP: capture, pulse `o_en_OP`, go to SHOW.
  - Load event in SHOW: behaves as LOAD_A. Capture, pulse `o_en_A`, go to LOAD_B, so a new calculation can be chained.
  - Clear event in any state: go to LOAD_A with no strobe. `o_data` keeps its value.
  - Load and clear events in the same cycle: clear wins, and no strobe is issued.
- `o_data` changes only on a load event and otherwise holds its last captured value.
- At most one of `o_en_A/B/OP` is high in any cycle.

## Timing
- **Reset** (`i_rst` = 0 at a rising edge):
  - `o_data` = 0, all strobes = 0, `o_state` = 0, `o_ready` = 0.
  - Synchronizer flops, debounced levels, previous-level copies and counters all go to 0.
  - Reset overrides everything, including a strobe in flight. A strobe due in the cycle after reset does not occur.
- **Event to output.** The load event is combinational in cycle t. `o_data`, the strobe and `o_state` update at the end of cycle t, so they are visible in cycle t+1. Each strobe lasts exactly 1 cycle.
- **Press to strobe.** With the button held high from cycle 0, the synchronized input is high from cycle 2 and the debounced level from cycle 2+DEBOUNCE_MAX. The strobe is high in cycle 3+DEBOUNCE_MAX.
- **Release.** Debounced 0 is accepted after the same delay; no strobe is generated.
- **Bounce.** A glitch shorter than `DEBOUNCE_MAX` cycles produces no level change and no event.
- **Holding the button** produces exactly one event per press, with no auto-repeat.
- **Switch path.** Switch changes reach `o_data` only through a capture. Switches must be stable 2 cycles before the event cycle.
- `o_ready` and `o_state` are registered and change in the same cycle as the corresponding strobe.

## Test plan
Run all scenarios with `DEBOUNCE_MAX` = 4.

- **Reset.** Hold `i_rst` = 0 for 3 cycles with buttons toggling → all outputs 0 and `o_state` = 0 throughout, and for 1 cycle after release.
- **Full sequence.** Three clean presses (8 cycles high, 8 low) with `i_sw` = 0x05, then 0x03, then 0x20 → `o_en_A` with `o_data` = 0x05, then `o_en_B` with 0x03, then `o_en_OP` with 0x20. Each strobe is 1 cycle, appearing 7 cycles after its press starts. `o_ready` = 1 and `o_state` = 3 after the third.
- **Bounce rejection.** Toggle `i_btn_load` 1-3 cycles high/low for 40 cycles, then hold high → exactly one `o_en_A`, 7 cycles after the final stable rise. No strobe during the bouncing.
- **Chaining.** From SHOW, press load with `i_sw` = 0x7F → `o_en_A` pulse, `o_data` = 0x7F, `o_state` = 1, `o_ready` = 0.
- **Clear priority.** In LOAD_OP, press load and clear simultaneously → no strobe, `o_state` = 0, `o_data` unchanged.
- **Reset mid-operation.** Assert `i_rst` = 0 in the cycle a load event fires → no strobe in the next cycle and all outputs 0. A following clean press yields `o_en_A`.
